program_loader_seq: RTL and testbench

Hardware bring-up sequencer for the single-cycle processor. On `start` it copies a program from an external source ROM into the processor's instruction memory, one word per clock, with `working` held low. It then asserts `working` until the processor reports `halt` or a cycle budget expires, drops `working`, and reads a contiguous window of registers back through `rID`/`rdata`. It sits between a program ROM and the processor's load/debug ports, and replaces hand-written load/run/readback stimulus in benches and on FPGA.

---
 rtl/program_loader_seq.sv | 92 +++++++++
 tb/tb_program_loader_seq.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/program_loader_seq.sv
// program_loader_seq: loads a program into instruction memory, runs the core, then dumps a register window
module program_loader_seq #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 9,
  parameter int PROG_LEN  = 12,
  parameter int REG_ID_W  = 4,
  parameter int DUMP_BASE = 3,
  parameter int NUM_DUMP  = 3,
  parameter int RUN_MAX   = 32
) (
  input  logic                clock,
  input  logic                rst_n,
  input  logic                start,
  output logic [ADDR_W-1:0]   prog_addr,
  input  logic [DATA_W-1:0]   prog_data,
  input  logic                halt,
  output logic [ADDR_W-1:0]   addr,
  output logic                wEn,
  output logic [DATA_W-1:0]   wDat,
  output logic                working,
  output logic [REG_ID_W-1:0] rID,
  input  logic [DATA_W-1:0]   rdata,
  output logic                dump_valid,
  output logic [REG_ID_W-1:0] dump_id,
  output logic [DATA_W-1:0]   dump_data,
  output logic                busy,
  output logic                done,
  output logic                timeout
);
  localparam int RW = RUN_MAX > 1 ? $clog2(RUN_MAX) : 1;
  localparam logic [ADDR_W-1:0]   LAST_K = ADDR_W'(PROG_LEN - 1);
  localparam logic [RW-1:0]       LAST_R = RW'(RUN_MAX - 1);
  localparam logic [REG_ID_W-1:0] LAST_J = REG_ID_W'(NUM_DUMP - 1);
  typedef enum logic [2:0] {IDLE, LOAD, RUN, SETTLE, DUMP, DONE} state_t;
  state_t              state;
  logic [ADDR_W-1:0]   k;
  logic [RW-1:0]       r;
  logic [REG_ID_W-1:0] j;
  logic                load;
  assign load      = state == LOAD;
  assign wEn       = load;
  assign addr      = load ? k : '0;
  assign prog_addr = load ? k : '0;
  assign wDat      = load ? prog_data : '0;
  assign working   = state == RUN;
  assign rID       = state == DUMP ? REG_ID_W'(DUMP_BASE) + j : '0;
  assign busy      = state inside {LOAD, RUN, SETTLE, DUMP};
  assign done      = state == DONE;
  // sequencer state, counters, sticky timeout and the one-cycle-late register dump strobe
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state      <= IDLE;
      k          <= '0;
      r          <= '0;
      j          <= '0;
      timeout    <= 1'b0;
      dump_valid <= 1'b0;
      dump_id    <= '0;
      dump_data  <= '0;
    end else begin
      dump_valid <= state == DUMP;
      if (state == DUMP) begin
        dump_id   <= rID;
        dump_data <= rdata;
      end
      case (state)
        IDLE, DONE: if (start) begin
          state   <= LOAD;
          k       <= '0;
          timeout <= 1'b0;
        end
        LOAD: if (k == LAST_K) begin
          state <= RUN;
          k     <= '0;
          r     <= '0;
        end else k <= k + 1'b1;
        RUN: if (halt) state <= SETTLE;
          else if (r == LAST_R) begin
            timeout <= 1'b1;
            state   <= SETTLE;
          end else r <= r + 1'b1;
        SETTLE: begin
          state <= DUMP;
          j     <= '0;
        end
        DUMP: if (j == LAST_J) state <= DONE;
          else j <= j + 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_program_loader_seq.sv
// tb_program_loader_seq: directed load/run/readback scenarios for program_loader_seq
module tb_program_loader_seq;
  logic        clock = 1'b0, rst_n = 1'b0, start = 1'b0, halt;
  logic [8:0]  prog_addr, addr;
  logic [31:0] prog_data, wDat, rdata, dump_data;
  logic        wEn, working, dump_valid, busy, done, timeout;
  logic [3:0]  rID, dump_id;
  logic [31:0] rom [12] = '{32'h10f00001, 32'h10f1000a, 32'h10f20003, 32'h00221820,
                            32'h00622022, 32'h14800002, 32'h10f30005, 32'h00832824,
                            32'h00a33025, 32'h2c070010, 32'h08000000, 32'h40500067};
  int          total = 0, bad = 0;
  int          halt_at = 1000, run_cnt = 0, ecnt = 0;
  logic        halt_force = 1'b0, mark = 1'b0;
  int          wen_n = 0, work_n = 0, dn = 0, done_at = 0, load_err = 0;
  logic [31:0] did [8], dd [8];

  program_loader_seq dut (
    .clock(clock), .rst_n(rst_n), .start(start), .prog_addr(prog_addr), .prog_data(prog_data),
    .halt(halt), .addr(addr), .wEn(wEn), .wDat(wDat), .working(working), .rID(rID),
    .rdata(rdata), .dump_valid(dump_valid), .dump_id(dump_id), .dump_data(dump_data),
    .busy(busy), .done(done), .timeout(timeout)
  );

  always #5 clock = ~clock;

  assign prog_data = prog_addr < 12 ? rom[prog_addr[3:0]] : 32'h0;
  assign rdata     = 32'h100 + {28'b0, rID};
  assign halt      = halt_force | (working && run_cnt == halt_at);

  // processor stub run counter and edge count since the marked start edge (start edge = 1)
  always @(posedge clock) begin
    run_cnt <= working ? run_cnt + 1 : 0;
    ecnt    <= mark ? 1 : ecnt + 1;
  end

  // per-run observation, restarted on the first cycle after a marked start
  always @(negedge clock) begin
    if (ecnt == 1) begin
      wen_n = 0; work_n = 0; dn = 0; done_at = 0; load_err = 0;
    end
    if (wEn) begin
      if (wen_n >= 12 || addr != wen_n[8:0] || prog_addr != addr || wDat != rom[wen_n] || working)
        load_err++;
      wen_n++;
    end
    if (working) work_n++;
    if (dump_valid && dn < 8) begin
      did[dn] = {28'b0, dump_id};
      dd[dn]  = dump_data;
      dn++;
    end
    if (done && done_at == 0) done_at = ecnt;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic go();
    @(negedge clock);
    start = 1'b1;
    mark  = 1'b1;
    @(negedge clock);
    start = 1'b0;
    mark  = 1'b0;
    #1;
    chk("start_done_low", {31'b0, done}, 32'd0);
    chk("start_busy", {31'b0, busy}, 32'd1);
    chk("start_wen_addr0", {22'b0, wEn, addr}, {22'b0, 1'b1, 9'd0});
  endtask

  task automatic wait_done();
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      #1;
      if (done) break;
    end
    chk("done_reached", {31'b0, done}, 32'd1);
  endtask

  task automatic check_run(input string nm, input int wk, input int to, input int dat);
    chk({nm, "_wen_cycles"}, wen_n, 12);
    chk({nm, "_load_err"}, load_err, 0);
    chk({nm, "_working_cycles"}, work_n, wk);
    chk({nm, "_timeout"}, {31'b0, timeout}, to);
    chk({nm, "_done_edge"}, done_at, dat);
    chk({nm, "_dump_count"}, dn, 3);
    for (int i = 0; i < 3; i++) begin
      chk({nm, "_dump_id"}, did[i], 32'd3 + i);
      chk({nm, "_dump_data"}, dd[i], 32'h103 + i);
    end
  endtask

  task automatic check_idle(input string nm);
    chk({nm, "_flags"}, {26'b0, busy, done, working, wEn, timeout, dump_valid}, 32'd0);
    chk({nm, "_addr"}, {23'b0, addr}, 32'd0);
    chk({nm, "_prog_addr"}, {23'b0, prog_addr}, 32'd0);
    chk({nm, "_wdat"}, wDat, 32'd0);
    chk({nm, "_rid"}, {28'b0, rID}, 32'd0);
    chk({nm, "_dump_id"}, {28'b0, dump_id}, 32'd0);
    chk({nm, "_dump_data"}, dump_data, 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clock);
    #1;
    check_idle("reset");
    rst_n = 1'b1;
    halt_at = 1000;
    go();
    wait_done();
    check_run("timeout_run", 32, 1, 49);
    halt_at = 9;
    go();
    wait_done();
    check_run("early_halt", 10, 0, 27);
    halt_at = 31;
    go();
    wait_done();
    check_run("halt_last", 32, 0, 49);
    halt_at = 0;
    go();
    wait_done();
    check_run("halt_first", 1, 0, 18);
    halt_at = 1000;
    go();
    for (int i = 0; i < 100; i++) begin
      if (ecnt == 18) break;
      @(negedge clock);
    end
    chk("mid_run_working", {31'b0, working}, 32'd1);
    rst_n = 1'b0;
    @(posedge clock);
    #1;
    check_idle("mid_reset");
    @(negedge clock);
    rst_n = 1'b1;
    halt_at = 2;
    go();
    wait_done();
    check_run("after_reset", 3, 0, 20);
    halt_at = 4;
    go();
    repeat (3) @(negedge clock);
    start = 1'b1;
    halt_force = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (2) @(negedge clock);
    halt_force = 1'b0;
    wait_done();
    check_run("restart_ignored", 5, 0, 22);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
